// File: rtl/cga_pkg.sv
// Shared constants and types for the CGA scan doubler.
// Contents: line buffer sizing, pixel word layout, bank select type,
// default output hsync width and line-period counter width.
package cga_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned LINE_MAX     = 2 ** ADDR_W_DEF;
    localparam int unsigned PERIOD_W_DEF = 12;
    localparam int unsigned HS_WIDTH_DEF = 64;
    localparam int unsigned PIX_W        = 5;

    // One stored pixel: display enable above the IRGB nibble.
    typedef struct packed {
        logic       de;
        logic [3:0] irgb;
    } pix_word_t;

    typedef logic bank_t;
    localparam bank_t BANK_0 = 1'b0;
    localparam bank_t BANK_1 = 1'b1;

endpackage

// File: rtl/cga_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, one write port, one registered
// read port, no reset on contents (maps onto iCE40 block RAM).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address {bank, pixel}
//   wdata  in   pixel word to store
//   raddr  in   read address {bank, pixel}
//   rdata  out  pixel word, one clk after raddr
module cga_linebuf
    import cga_pkg::*;
#(
    parameter int unsigned AW = ADDR_W_DEF + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pix_word_t     wdata,
    input  logic [AW-1:0] raddr,
    output pix_word_t     rdata
);

    logic [PIX_W-1:0] mem [2 ** AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= pix_word_t'(mem[raddr]);
    end

endmodule

// File: rtl/cga_scandoubler.sv
// CGA line doubler: captures each native line into one bank of a ping-pong
// buffer and replays the previously captured line twice at double rate.
// Optional feature macro: SCANDOUBLER_SCANLINES_EN (darkens the 2nd replay).
// Ports:
//   clk, busreset                    clock, synchronous active-high reset
//   pix_en, video, display_enable    native pixel strobe and pixel data
//   hsync, vsync                     native syncs, active-high
//   dbl_video, dbl_display_enable    doubled-rate pixel stream, one per clk
//   dbl_hsync, dbl_vsync             doubled-rate syncs
//   line_ovf                         1-clk pulse when a line exceeds the buffer
module cga_scandoubler
    import cga_pkg::*;
#(
    parameter int unsigned ADDR_W   = $clog2(LINE_MAX),
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned HS_WIDTH = HS_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       busreset,
    input  logic       pix_en,
    input  logic [3:0] video,
    input  logic       display_enable,
    input  logic       hsync,
    input  logic       vsync,
    output logic [3:0] dbl_video,
    output logic       dbl_display_enable,
    output logic       dbl_hsync,
    output logic       dbl_vsync,
    output logic       line_ovf
);

    localparam int unsigned CNT_W = PERIOD_W - 1;
    localparam logic [ADDR_W:0] LINE_FULL = {1'b1, {ADDR_W{1'b0}}};

`ifdef SCANDOUBLER_SCANLINES_EN
    localparam logic SCANLINES_ON = 1'b1;
`else
    localparam logic SCANLINES_ON = 1'b0;
`endif

    logic                hsync_q;
    bank_t               wr_bank;
    logic [ADDR_W:0]     wr_addr;
    logic [ADDR_W:0]     line_len [2];
    logic                ovf_seen;
    logic [PERIOD_W-1:0] period_cnt;
    logic [CNT_W-1:0]    half;
    logic [CNT_W-1:0]    out_cnt;
    logic                phase;
    logic                rise_seen;
    logic                valid;
    logic                v1, hs1, vs1, in_range1, phase1;
    pix_word_t           rd_word;

    logic                hs_rise_c;
    bank_t               rd_bank_c;
    logic                wr_en_c;
    pix_word_t           wr_word_c;
    logic [ADDR_W:0]     ram_waddr_c;
    logic [ADDR_W:0]     ram_raddr_c;
    logic                in_range_c;
    logic                hs_raw_c;
    logic [PERIOD_W-1:0] cnt_inc_c;
    logic                wrap_c;
    logic                dark_c;

    // Edge detect, bank selection and read-side decode.
    always_comb begin
        hs_rise_c   = hsync & ~hsync_q;
        rd_bank_c   = (wr_bank == BANK_0) ? BANK_1 : BANK_0;
        // wr_addr saturates at LINE_MAX: the buffer is full, further pixels drop.
        wr_en_c     = pix_en & (wr_addr != LINE_FULL);
        wr_word_c   = '{de: display_enable, irgb: video};
        ram_waddr_c = {wr_bank, wr_addr[ADDR_W-1:0]};
        ram_raddr_c = {rd_bank_c, ADDR_W'(out_cnt)};
        in_range_c  = 32'(out_cnt) < 32'(line_len[rd_bank_c]);
        hs_raw_c    = 32'(out_cnt) < HS_WIDTH;
        cnt_inc_c   = PERIOD_W'(out_cnt) + PERIOD_W'(1);
        wrap_c      = cnt_inc_c >= PERIOD_W'(half);
        dark_c      = SCANLINES_ON & phase1;
    end

    cga_linebuf #(
        .AW (ADDR_W + 1)
    ) u_linebuf (
        .clk   (clk),
        .we    (wr_en_c),
        .waddr (ram_waddr_c),
        .wdata (wr_word_c),
        .raddr (ram_raddr_c),
        .rdata (rd_word)
    );

    // Capture, period measurement, replay counter and two-stage output pipe.
    always_ff @(posedge clk) begin
        if (busreset) begin
            hsync_q            <= 1'b0;
            wr_bank            <= BANK_0;
            wr_addr            <= '0;
            line_len[0]        <= '0;
            line_len[1]        <= '0;
            ovf_seen           <= 1'b0;
            period_cnt         <= '0;
            half               <= '0;
            out_cnt            <= '0;
            phase              <= 1'b0;
            rise_seen          <= 1'b0;
            valid              <= 1'b0;
            v1                 <= 1'b0;
            hs1                <= 1'b0;
            vs1                <= 1'b0;
            in_range1          <= 1'b0;
            phase1             <= 1'b0;
            dbl_video          <= 4'h0;
            dbl_display_enable <= 1'b0;
            dbl_hsync          <= 1'b0;
            dbl_vsync          <= 1'b0;
            line_ovf           <= 1'b0;
        end else begin
            hsync_q <= hsync;

            // A pixel coinciding with hs_rise lands in the old bank but is
            // not counted in that line's length.
            if (hs_rise_c) begin
                line_len[wr_bank] <= wr_addr;
                wr_addr           <= '0;
                wr_bank           <= rd_bank_c;
                ovf_seen          <= 1'b0;
            end else if (pix_en) begin
                if (wr_en_c) begin
                    wr_addr <= wr_addr + (ADDR_W + 1)'(1);
                end else begin
                    ovf_seen <= 1'b1;
                end
            end
            line_ovf <= pix_en & ~wr_en_c & ~ovf_seen & valid;

            if (hs_rise_c) begin
                half       <= period_cnt[PERIOD_W-1:1];
                period_cnt <= PERIOD_W'(1);
            end else if (period_cnt != '1) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end

            // The first line after reset has no complete predecessor to replay.
            if (hs_rise_c) begin
                rise_seen <= 1'b1;
                if (rise_seen) begin
                    valid <= 1'b1;
                end
            end

            // hs_rise restarts the replay even if the 2nd pass is unfinished.
            if (hs_rise_c) begin
                out_cnt <= '0;
                phase   <= 1'b0;
            end else if (wrap_c) begin
                out_cnt <= '0;
                phase   <= ~phase;
            end else begin
                out_cnt <= CNT_W'(cnt_inc_c);
            end

            v1        <= valid;
            hs1       <= hs_raw_c;
            vs1       <= vsync;
            in_range1 <= in_range_c;
            phase1    <= phase;

            if (v1) begin
                dbl_video          <= (in_range1 && !dark_c) ? rd_word.irgb : 4'h0;
                dbl_display_enable <= in_range1 & rd_word.de;
                dbl_hsync          <= hs1;
                dbl_vsync          <= vs1;
            end else begin
                dbl_video          <= 4'h0;
                dbl_display_enable <= 1'b0;
                dbl_hsync          <= 1'b0;
                dbl_vsync          <= 1'b0;
            end
        end
    end

endmodule
